// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command slave and its byte engines.
package uart_pkg;
  localparam int CMD_W            = 16;
  localparam int BYTE_W           = 8;
  localparam int TIMEOUT_CLKS_DEF = 100000;
  localparam int BAUD_DIV         = 16;

  typedef enum logic {HIGH, LOW} rx_frame_t;
endpackage

// File: rtl/UART_rx.sv
// UART byte receiver: samples mid-bit, raises rdy after the stop bit until clr_ready or next start.
module UART_rx import uart_pkg::*; #(
  parameter int BAUD = BAUD_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  input  logic              clr_ready,
  output logic              rdy,
  output logic [BYTE_W-1:0] cmd
);
  localparam int BW = $clog2(2 * BAUD);

  logic          rx_meta, rx_s, busy;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      rdy      <= 1'b0;
      cmd      <= '0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      if (clr_ready)
        rdy <= 1'b0;
      if (busy) begin
        if (baud_cnt == '0) begin
          baud_cnt <= BW'(BAUD - 1);
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            busy <= 1'b0;
            rdy  <= 1'b1;
          end else begin
            cmd <= {rx_s, cmd[BYTE_W-1:1]};
          end
        end else begin
          baud_cnt <= baud_cnt - 1'b1;
        end
      end else if (!rx_s) begin
        // first sample lands in the middle of data bit 0
        busy     <= 1'b1;
        bit_cnt  <= '0;
        baud_cnt <= BW'(BAUD + BAUD / 2 - 1);
        rdy      <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/UART_tx.sv
// UART byte transmitter: 1 start, 8 data LSB first, 1 stop; tx_done sticky until next trmt.
module UART_tx import uart_pkg::*; #(
  parameter int BAUD = BAUD_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              TX,
  output logic              tx_done
);
  localparam int BW = $clog2(2 * BAUD);

  logic [9:0]    shft;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic          busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft     <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else if (trmt) begin
      shft     <= {1'b1, tx_data, 1'b0};
      bit_cnt  <= '0;
      baud_cnt <= BW'(BAUD - 1);
      busy     <= 1'b1;
      tx_done  <= 1'b0;
    end else if (busy) begin
      if (baud_cnt == '0) begin
        shft     <= {1'b1, shft[9:1]};
        baud_cnt <= BW'(BAUD - 1);
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd9) begin
          busy    <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  assign TX = shft[0];
endmodule

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, flags the last allowed cycle.
module uart_frame_timer #(
  parameter int TIMEOUT_CLKS = 100000,
  parameter int TMR_W        = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

  assign expired = en && (count == TMR_W'(TIMEOUT_CLKS - 1));
endmodule

// File: rtl/uart_cmd_slave.sv
// Two-byte command deserialiser and single-byte response sender over UART.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_slave import uart_pkg::*; #(
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
  parameter int TMR_W        = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  output logic              resp_sent
);
  rx_frame_t         state, nxt_state;
  logic              rx_rdy, clr_ready, trmt, tx_done;
  logic [BYTE_W-1:0] rx_byte, high_byte;
  logic              cap_hi, cap_lo, drop_hi, expired, tx_busy;

  UART_rx u_rx (.clk(clk), .rst_n(rst_n), .RX(RX), .clr_ready(clr_ready),
                .rdy(rx_rdy), .cmd(rx_byte));

  UART_tx u_tx (.clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(resp),
                .TX(TX), .tx_done(tx_done));

`ifdef CMD_TIMEOUT_EN
  logic tmr_en;
  assign tmr_en = (state == LOW);
  uart_frame_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS), .TMR_W(TMR_W)) u_tmr (
    .clk(clk), .rst_n(rst_n), .clr(cap_hi), .en(tmr_en), .expired(expired));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HIGH;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    clr_ready = 1'b0;
    cap_hi    = 1'b0;
    cap_lo    = 1'b0;
    drop_hi   = 1'b0;
    case (state)
      HIGH: if (rx_rdy) begin
        cap_hi    = 1'b1;
        clr_ready = 1'b1;
        nxt_state = LOW;
      end
      LOW: if (rx_rdy) begin
        cap_lo    = 1'b1;
        clr_ready = 1'b1;
        nxt_state = HIGH;
      end else if (expired) begin
        drop_hi   = 1'b1;
        nxt_state = HIGH;
      end
      default: nxt_state = HIGH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (cap_hi)       high_byte <= rx_byte;
      else if (drop_hi) high_byte <= '0;
      if (cap_lo)
        cmd <= {high_byte, rx_byte};
      // frame completion beats a simultaneous consumer acknowledge
      if (cap_lo)                     cmd_rdy <= 1'b1;
      else if (cap_hi || clr_cmd_rdy) cmd_rdy <= 1'b0;
    end
  end

  assign trmt = send_resp && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
    end else if (trmt) begin
      tx_busy   <= 1'b1;
      resp_sent <= 1'b0;
    end else if (tx_busy && tx_done) begin
      tx_busy   <= 1'b0;
      resp_sent <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_slave.sv
// Scoreboard bench for uart_cmd_slave: serial master model, RX/TX monitors, random full-duplex traffic.
module tb_uart_cmd_slave;
  import uart_pkg::*;
`ifdef CMD_TIMEOUT_EN
  localparam int TB_TMO = 5000;
`else
  localparam int TB_TMO = 100000;
`endif
  localparam int B = BAUD_DIV;

  logic        clk = 1'b0, rst_n = 1'b0, RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, resp_sent;
  logic [15:0] cmd;

  int errors = 0, checks = 0;
  int rst_epoch = 0, clr_pulses = 0, bytes_sent = 0, cyc = 0;
  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_tx_q[$];

  always #5 clk = ~clk;

  uart_cmd_slave #(.TIMEOUT_CLKS(TB_TMO), .TMR_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // caller is at a negedge; returns at a negedge so bytes chain with no idle gap
  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
    bytes_sent++;
  endtask

  task automatic send_frame(input logic [15:0] c);
    exp_cmd_q.push_back(c);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  task automatic do_resp(input logic [7:0] r, input bit push, output int start_cyc);
    resp = r;
    send_resp = 1'b1;
    start_cyc = cyc;
    if (push) exp_tx_q.push_back(r);
    @(negedge clk);
    send_resp = 1'b0;
    resp = 8'($urandom);
    if (push) check("resp_sent_clr", resp_sent, 1'b0);
  endtask

  task automatic wait_resp_sent();
    int n = 0;
    while (!resp_sent && n < 20 * B) begin
      @(negedge clk);
      n++;
    end
    check("resp_sent_seen", resp_sent, 1'b1);
  endtask

  initial forever @(posedge clk) cyc++;
  initial forever @(negedge rst_n) rst_epoch++;
  initial forever @(negedge clk) if (rst_n && dut.clr_ready) clr_pulses++;

  // command monitor: each cmd_rdy rise must present the next expected command
  initial begin
    logic pr = 1'b0;
    logic [15:0] pc = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr = 1'b0;
        pc = cmd;
      end else begin
        if (cmd_rdy && !pr) begin
          check("cmd_q_nonempty", 32'(exp_cmd_q.size() > 0), 1);
          if (exp_cmd_q.size() > 0) check("cmd", cmd, exp_cmd_q.pop_front());
        end else if (cmd !== pc) begin
          check("cmd_changed_without_rdy", cmd, pc);
        end
        pr = cmd_rdy;
        pc = cmd;
      end
    end
  end

  // TX monitor: decodes bytes off the line; frames cut by reset are discarded
  initial begin
    int ep;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        ep = rst_epoch;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          d[i] = TX;
        end
        repeat (B) @(negedge clk);
        if (ep == rst_epoch && rst_n) begin
          check("tx_stop_bit", TX, 1'b1);
          check("tx_q_nonempty", 32'(exp_tx_q.size() > 0), 1);
          if (exp_tx_q.size() > 0) check("tx_byte", d, exp_tx_q.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0, s0, n;
    bit done_rx;
    repeat (3) @(negedge clk);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_resp_sent", resp_sent, 1'b0);
    check("rst_tx", TX, 1'b1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    c0 = clr_pulses;
    send_frame(16'hA55A);
    check("a55a_cmd", cmd, 16'hA55A);
    check("a55a_rdy", cmd_rdy, 1'b1);
    repeat (4) @(negedge clk);
    check("a55a_clr_ready_pulses", clr_pulses - c0, 2);

    send_frame(16'h1234);
    check("b2b_rdy1", cmd_rdy, 1'b1);
    exp_cmd_q.push_back(16'hBEEF);
    send_byte(8'hBE);
    check("b2b_rdy_fall", cmd_rdy, 1'b0);
    check("b2b_cmd_hold", cmd, 16'h1234);
    send_byte(8'hEF);
    check("b2b_cmd2", cmd, 16'hBEEF);
    check("b2b_rdy2", cmd_rdy, 1'b1);

    clr_cmd_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_cmd_rdy", cmd_rdy, 1'b0);
    fork
      send_frame(16'h00FF);
      begin
        n = 0;
        while (!cmd_rdy && n < 40 * B) begin
          @(negedge clk);
          n++;
        end
        clr_cmd_rdy = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("set_wins", cmd_rdy, 1'b1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("lone_clr", cmd_rdy, 1'b0);

    do_resp(8'hA5, 1'b1, s0);
    repeat (3 * B) @(negedge clk);
    do_resp(8'h3C, 1'b0, c0);
    check("resp_busy_ignored", resp_sent, 1'b0);
    wait_resp_sent();
    check("resp_latency_ok", 32'((cyc - s0) >= 10 * B + 1 && (cyc - s0) <= 10 * B + 3), 1);
    check("tx_only_a5", exp_tx_q.size(), 0);
    do_resp(8'h3C, 1'b1, s0);
    wait_resp_sent();

`ifdef CMD_TIMEOUT_EN
    send_byte(8'h77);
    repeat (6000) @(negedge clk);
    send_frame(16'hC3D2);
    check("timeout_cmd", cmd, 16'hC3D2);
`endif

    send_byte(8'hDE);
    do_resp(8'h5A, 1'b0, s0);
    repeat (B + B / 2) @(negedge clk);
    check("tx_inflight_low", TX, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_tx_abort", TX, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_cmd_rdy", cmd_rdy, 1'b0);
      check("rst_mid_resp_sent", resp_sent, 1'b0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(16'hCAFE);
    check("after_rst_cmd", cmd, 16'hCAFE);

    done_rx = 1'b0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          repeat ($urandom_range(0, 2) * B) @(negedge clk);
          send_frame(16'($urandom));
        end
        done_rx = 1'b1;
      end
      begin
        for (int r = 0; r < 5; r++) begin
          do_resp(8'($urandom), 1'b1, s0);
          wait_resp_sent();
          repeat ($urandom_range(0, B)) @(negedge clk);
        end
      end
      begin
        while (!done_rx) begin
          repeat ($urandom_range(B, 8 * B)) @(negedge clk);
          clr_cmd_rdy = 1'b1;
          @(negedge clk);
          clr_cmd_rdy = 1'b0;
        end
      end
    join

    repeat (4 * B) @(negedge clk);
    check("cmd_q_drained", exp_cmd_q.size(), 0);
    check("tx_q_drained", exp_tx_q.size(), 0);
    check("clr_ready_per_byte", clr_pulses, bytes_sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cmd_slave.md
Name: uart_cmd_slave

Overview:
- Receive-side partner of the master command link: deserialises the two-byte command stream (high byte first, then low byte) into a 16-bit command for the design core.
- Serialises a single 8-bit response byte back to the master.
- Sits between the RX/TX pins and the command processor. Instantiates the team's existing UART_rx and UART_tx byte engines and adds framing, flag and handshake control.

Parameters:
- TIMEOUT_CLKS, 100000, clocks allowed between high-byte capture and low-byte arrival (used only with CMD_TIMEOUT_EN).
- TMR_W, 17, width of the inter-byte timeout counter; must satisfy 2^TMR_W > TIMEOUT_CLKS.

Ports:
- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  asynchronous active-low reset.
- RX  input  1  serial in from master (idle high).
- TX  output  1  serial out to master (idle high).
- cmd  output  16  assembled command {high_byte, low_byte}.
- cmd_rdy  output  1  sticky flag: new cmd valid.
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
- resp  input  8  response byte, sampled on send_resp.
- send_resp  input  1  single-cycle request to transmit resp.
- resp_sent  output  1  sticky flag: last response fully shifted out.

Behaviour:
- Reset values: cmd=16'h0000, cmd_rdy=0, resp_sent=0, TX=1, state=HIGH, internal high_byte=8'h00, tx_busy=0, timer=0.
- Byte engines: UART_rx (.rdy, .cmd[7:0], .clr_ready) and UART_tx (.trmt, .tx_data, .tx_done). The slave drives clr_ready high for exactly one cycle per consumed byte.
- Receive FSM, state type {HIGH, LOW}:
  - HIGH, rx rdy=1:
    - high_byte <= rx byte; pulse clr_ready; go LOW.
    - Clear cmd_rdy in the same cycle, because a new frame has begun.
  - HIGH, rdy=0: stay.
  - LOW, rx rdy=1:
    - cmd <= {high_byte, rx byte}; pulse clr_ready; go HIGH.
    - Set cmd_rdy on the next edge. Latency is 1 clk after rdy is sampled.
  - LOW, rdy=0: stay.
- cmd holds stable from assembly until the next low-byte capture. A partially received frame never alters cmd.
- cmd_rdy priority: set (frame complete) beats clr_cmd_rdy in the same cycle. clr_cmd_rdy while cmd_rdy=0 has no effect.
- Response path:
  - send_resp=1 with tx_busy=0: latch resp and pulse trmt for 1 cycle; tx_busy<=1; resp_sent<=0.
  - send_resp while tx_busy=1: ignored. No queuing, and resp_sent stays 0.
  - tx_done rising (first cycle seen while tx_busy): tx_busy<=0; resp_sent<=1.
  - resp_sent stays set until the next accepted send_resp.
- Simultaneous receive and transmit are fully independent; full duplex is required.
- Async reset mid-frame: FSM returns to HIGH. A half-received frame is discarded. Any in-flight TX is aborted and TX is forced high immediately.
- Back-to-back frames with zero idle gap between stop and start bits must be assembled without loss.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to LOW and increments each clk in LOW.
  - When count == TIMEOUT_CLKS-1 with no rdy: return to HIGH, discard high_byte, leave cmd/cmd_rdy untouched.
  - rdy arriving in the same cycle as expiry wins: the frame completes.
  - This recovers byte alignment after a dropped byte.
- Undefined: no counter is synthesised and LOW waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - Enum rx_frame_t {HIGH, LOW}.
  - Localparams CMD_W=16 and BYTE_W=8.
  - Default TIMEOUT_CLKS constant.
- One natural sub-module: uart_frame_timer, the CMD_TIMEOUT_EN counter with clr/en/expired, kept separate so it vanishes cleanly when the macro is off.
- UART_rx and UART_tx are reused as is.

Test Plan:
- Master-driven cmd 16'hA55A via the master link → cmd=16'hA55A, cmd_rdy=1 one clk after the low byte's rdy, with exactly two clr_ready pulses.
- Two back-to-back frames 16'h1234 then 16'hBEEF with no clr_cmd_rdy → cmd_rdy falls at the high-byte capture of frame 2 and rises again with cmd=16'hBEEF; cmd reads 16'h1234 until that point.
- clr_cmd_rdy asserted in the same cycle as frame completion of 16'h00FF → cmd_rdy=1 (set wins); a later lone clr_cmd_rdy → 0.
- send_resp with resp=8'hA5, plus a second send_resp(8'h3C) mid-transmission → only 0xA5 is observed on TX; resp_sent rises after the stop bit; the next send_resp(8'h3C) clears resp_sent and then transmits 0x3C.
- With CMD_TIMEOUT_EN and TIMEOUT_CLKS=5000, send lone byte 8'h77, idle 6000 clks, then frame 16'hC3D2 → cmd=16'hC3D2 (not 16'h77C3).
- rst_n low for 3 clks after the high byte of 16'hDEAD, then send 16'hCAFE → cmd=16'hCAFE, with cmd_rdy and resp_sent both 0 during reset.
